regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Shares the register file's single write port (`we3`/`a3`/`wd3`) between the in-order pipeline writeback (port 0) and a long-latency unit such as a divider or load return (port 1). It also keeps a scoreboard of destination registers owned by outstanding long-latency operations, so decode can stall on hazards. It sits between the writeback stage and `regfile`, and drives the write port through one register stage.

## Interface
Parameters:
- `STARVE_MAX`, default 4: consecutive cycles port 1 may wait before it is forced ahead of port 0. Legal range 1..15.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `p0_valid` in 1: pipeline writeback request.
- `p0_rd` in 5: pipeline destination register.
- `p0_wd` in 32: pipeline write data.
- `p0_ready` out 1: port 0 request is accepted this cycle.
- `p1_valid` in 1: long-latency unit writeback request.
- `p1_rd` in 5: long-latency destination register.
- `p1_wd` in 32: long-latency write data.
- `p1_ready` out 1: port 1 request is accepted this cycle.
- `iss_valid` in 1: a long-latency op is issued this cycle.
- `iss_rd` in 5: destination register of the issued op.
- `chk_a1` in 5: decode source register 1 to check.
- `chk_a2` in 5: decode source register 2 to check.
- `hazard` out 1: combinational; a checked source is busy or has a write in flight.
- `we3` out 1: registered write enable to `regfile`.
- `a3` out 5: registered write address to `regfile`.
- `wd3` out 32: registered write data to `regfile`.

## Operation
- Handshake: a request transfers on the cycle where valid and ready are both high. Requesters hold rd/wd stable while valid is high and not accepted.
- `force` = (`starve_cnt` == `STARVE_MAX`).
- `p0_ready` = !(`force` && `p1_valid`).
- `p1_ready` = !`p0_valid` || `force`.
- At most one transfer per cycle. When both valid and not `force`, port 0 wins.
- `starve_cnt` (4 bits):
  - Cleared when `p1_valid` is low or port 1 transfers.
  - Otherwise +1 per cycle, saturating at `STARVE_MAX`.
- Write stage, at the edge after a transfer:
  - `we3` <= (rd != 0).
  - `a3` <= rd.
  - `wd3` <= wd.
- With no transfer, `we3` <= 0; `a3`/`wd3` hold their values.
- rd = 0: the handshake completes but no write is issued.
- Scoreboard `busy[31:0]`, `busy[0]` always 0:
  - Set: `iss_valid` && `iss_rd` != 0 sets `busy[iss_rd]`.
  - Clear: a port 1 transfer clears `busy[p1_rd]`.
  - Same register set and cleared in one cycle: set wins.
  - Issue to an already-busy register: it stays busy. There is no count.
  - Port 0 writes never clear busy.
- `hazard` = OR over i in {1,2} of (`chk_ai` != 0 && (`busy[chk_ai]` || (`we3` && `a3` == `chk_ai`))).

## Timing
- Reset values:
  - `we3` = 0, `a3` = 0, `wd3` = 0.
  - `busy` = 0, `starve_cnt` = 0.
  - Therefore `hazard` = 0, `p0_ready` = 1, `p1_ready` = 1.
- Latency: a transfer at edge N gives `we3` high during cycle N+1; `regfile` commits at edge N+1.
- Ready outputs and `hazard` are combinational from inputs and state, with no registered delay.
- Back-to-back transfers every cycle are supported. Full write-port throughput is 1 per cycle.
- Reset asserted mid-operation: in-flight write dropped (`we3` = 0 next cycle), scoreboard and counter cleared. Requesters must reissue.
- `force` lasts until port 1 transfers (one cycle, since `p1_ready` = 1). The counter then restarts from 0.

## Configuration
- `REGFILE_ARB_SCOREBOARD_EN` defined: the scoreboard is built, and `hazard` is as specified above.
- Undefined:
  - No `busy` storage; `iss_valid`/`iss_rd` are ignored.
  - `hazard` covers only the in-flight write term (`we3` && `a3` matches a nonzero `chk_ai`).
  - Arbitration and the write stage are unchanged.

## Test plan
- Reset, then idle: `we3` = 0, `hazard` = 0, both ready = 1. Then p0 writes x5 = 0xDEADBEEF: `we3` = 1, `a3` = 5, `wd3` = 0xDEADBEEF exactly one cycle later.
- Both ports valid continuously, `STARVE_MAX` = 4: p0 granted 4 cycles, p1 granted on the 5th with `p0_ready` = 0. The pattern repeats 4:1.
- Issue to x7 (`iss_rd` = 7), then `chk_a1` = 7: `hazard` = 1. After the p1 write of x7 is accepted, `hazard` = 1 for one more cycle (in-flight write), then 0.
- Same-cycle `iss_rd` = 9 and p1 transfer with `p1_rd` = 9: `busy[9]` stays 1. A p0 write to x9 leaves `busy[9]` = 1.
- rd = 0 from either port, and `iss_rd` = 0: handshake completes, `we3` stays 0, and `hazard` with `chk_a1` = 0 is 0.
- `reset` asserted with `busy[3]` = 1, `starve_cnt` = 2 and a write in flight: next cycle `we3` = 0, `hazard` = 0 for `chk_a1` = 3, counter 0.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//
// Shares the register file's single write port between the in-order pipeline
// writeback (port 0) and a long-latency unit such as a divider or load return
// (port 1). The winning request is registered onto we3/a3/wd3 one cycle after
// the handshake. A scoreboard of destination registers owned by outstanding
// long-latency ops lets decode stall on hazards.
//
// Configuration macro: REGFILE_ARB_SCOREBOARD_EN
//   defined   - busy[31:0] scoreboard built; hazard covers busy and in-flight writes
//   undefined - no scoreboard; iss_valid/iss_rd ignored; hazard covers only
//               the in-flight write
//
// Parameters:
//   STARVE_MAX  consecutive waiting cycles before port 1 is forced ahead (1..15)
//
// Ports:
//   clk, reset                clock (rising edge), synchronous active-high reset
//   p0_valid/p0_rd/p0_wd      pipeline writeback request
//   p0_ready                  port 0 accepted this cycle
//   p1_valid/p1_rd/p1_wd      long-latency writeback request
//   p1_ready                  port 1 accepted this cycle
//   iss_valid/iss_rd          long-latency op issued, and its destination
//   chk_a1/chk_a2             decode source registers to check
//   hazard                    combinational: a checked source is busy/in flight
//   we3/a3/wd3                registered write port to regfile

module regfile_wb_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p0_valid,
  input  logic [4:0]  p0_rd,
  input  logic [31:0] p0_wd,
  output logic        p0_ready,
  input  logic        p1_valid,
  input  logic [4:0]  p1_rd,
  input  logic [31:0] p1_wd,
  output logic        p1_ready,
  input  logic        iss_valid,
  input  logic [4:0]  iss_rd,
  input  logic [4:0]  chk_a1,
  input  logic [4:0]  chk_a2,
  output logic        hazard,
  output logic        we3,
  output logic [4:0]  a3,
  output logic [31:0] wd3
);

  localparam logic [3:0] STARVE_LIMIT = 4'(STARVE_MAX);

  logic [3:0] starve_cnt;
  logic       starve_force;
  logic       p0_xfer;
  logic       p1_xfer;
  logic       hz1;
  logic       hz2;

  // Port 0 normally wins; once port 1 has waited STARVE_LIMIT cycles it is
  // pushed ahead for exactly one cycle. The two ready terms never allow both
  // ports to transfer in the same cycle.
  assign starve_force = (starve_cnt == STARVE_LIMIT);
  assign p0_ready     = !(starve_force && p1_valid);
  assign p1_ready     = !p0_valid || starve_force;
  assign p0_xfer      = p0_valid && p0_ready;
  assign p1_xfer      = p1_valid && p1_ready;

  // Starvation counter: counts cycles port 1 has been left waiting, restarting
  // whenever it is idle or gets through.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= 4'd0;
    end else if (!p1_valid || p1_xfer) begin
      starve_cnt <= 4'd0;
    end else if (starve_cnt != STARVE_LIMIT) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // Write stage: the accepted request is presented to the regfile on the next
  // cycle. A transfer to x0 completes the handshake but does not raise we3.
  // Address and data hold when idle so only we3 has to toggle.
  always_ff @(posedge clk) begin
    if (reset) begin
      we3 <= 1'b0;
      a3  <= 5'd0;
      wd3 <= 32'd0;
    end else if (p1_xfer) begin
      we3 <= (p1_rd != 5'd0);
      a3  <= p1_rd;
      wd3 <= p1_wd;
    end else if (p0_xfer) begin
      we3 <= (p0_rd != 5'd0);
      a3  <= p0_rd;
      wd3 <= p0_wd;
    end else begin
      we3 <= 1'b0;
    end
  end

`ifdef REGFILE_ARB_SCOREBOARD_EN
  logic [31:0] busy;
  logic [31:0] busy_next;

  // Scoreboard update: the clear from a port 1 writeback is applied first so a
  // same-cycle issue to the same register wins. Port 0 never clears a bit.
  always_comb begin
    busy_next = busy;
    if (p1_xfer) begin
      busy_next[p1_rd] = 1'b0;
    end
    if (iss_valid && (iss_rd != 5'd0)) begin
      busy_next[iss_rd] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= 32'd0;
    end else begin
      busy <= busy_next;
    end
  end

  // A source is hazardous if an outstanding op owns it or its write is still
  // sitting in the write stage and has not reached the regfile yet.
  always_comb begin
    hz1 = (chk_a1 != 5'd0) && (busy[chk_a1] || (we3 && (a3 == chk_a1)));
    hz2 = (chk_a2 != 5'd0) && (busy[chk_a2] || (we3 && (a3 == chk_a2)));
  end
`else
  logic unused_iss;

  assign unused_iss = ^{iss_valid, iss_rd};

  // Without a scoreboard only the in-flight write can cause a hazard.
  always_comb begin
    hz1 = (chk_a1 != 5'd0) && we3 && (a3 == chk_a1);
    hz2 = (chk_a2 != 5'd0) && we3 && (a3 == chk_a2);
  end
`endif

  assign hazard = hz1 || hz2;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter
//
// Directed testbench for regfile_wb_arbiter with STARVE_MAX = 4. Inputs are
// driven 1ns after the rising edge; combinational outputs are checked after a
// further 1ns, registered outputs 1ns after the following edge. Expected
// hazard values depend on whether REGFILE_ARB_SCOREBOARD_EN is defined.

module tb_regfile_wb_arbiter;

`ifdef REGFILE_ARB_SCOREBOARD_EN
  localparam logic SB = 1'b1;
`else
  localparam logic SB = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        p0_valid;
  logic [4:0]  p0_rd;
  logic [31:0] p0_wd;
  logic        p0_ready;
  logic        p1_valid;
  logic [4:0]  p1_rd;
  logic [31:0] p1_wd;
  logic        p1_ready;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic [4:0]  chk_a1;
  logic [4:0]  chk_a2;
  logic        hazard;
  logic        we3;
  logic [4:0]  a3;
  logic [31:0] wd3;

  int testsRun;
  int testsFailed;

  regfile_wb_arbiter #(.STARVE_MAX(4)) dut (
    .clk(clk),
    .reset(reset),
    .p0_valid(p0_valid),
    .p0_rd(p0_rd),
    .p0_wd(p0_wd),
    .p0_ready(p0_ready),
    .p1_valid(p1_valid),
    .p1_rd(p1_rd),
    .p1_wd(p1_wd),
    .p1_ready(p1_ready),
    .iss_valid(iss_valid),
    .iss_rd(iss_rd),
    .chk_a1(chk_a1),
    .chk_a2(chk_a2),
    .hazard(hazard),
    .we3(we3),
    .a3(a3),
    .wd3(wd3)
  );

  // Free-running 10ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    if (obs !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drives every request input at once and lets combinational outputs settle.
  task automatic applyStimulus(input logic v0, input logic [4:0] rd0, input logic [31:0] wdat0,
                               input logic v1, input logic [4:0] rd1, input logic [31:0] wdat1,
                               input logic iv, input logic [4:0] ird);
    p0_valid  = v0;
    p0_rd     = rd0;
    p0_wd     = wdat0;
    p1_valid  = v1;
    p1_rd     = rd1;
    p1_wd     = wdat1;
    iss_valid = iv;
    iss_rd    = ird;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    reset  = 1'b1;
    chk_a1 = 5'd0;
    chk_a2 = 5'd0;
    idle();
    tick();
    tick();
    reset = 1'b0;

    // Reset / idle state.
    chk_a1 = 5'd5;
    #1;
    checkOutput("reset_we3", 32'(we3), 32'd0);
    checkOutput("reset_a3", 32'(a3), 32'd0);
    checkOutput("reset_wd3", wd3, 32'd0);
    checkOutput("reset_hazard", 32'(hazard), 32'd0);
    checkOutput("reset_p0_ready", 32'(p0_ready), 32'd1);
    checkOutput("reset_p1_ready", 32'(p1_ready), 32'd1);

    // p0 writes x5 and it appears on the write port one cycle later.
    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    checkOutput("p0w_ready", 32'(p0_ready), 32'd1);
    tick();
    idle();
    checkOutput("p0w_we3", 32'(we3), 32'd1);
    checkOutput("p0w_a3", 32'(a3), 32'd5);
    checkOutput("p0w_wd3", wd3, 32'hDEADBEEF);
    checkOutput("p0w_hazard_inflight", 32'(hazard), 32'd1);
    tick();
    checkOutput("p0w_we3_drop", 32'(we3), 32'd0);
    checkOutput("p0w_a3_hold", 32'(a3), 32'd5);
    checkOutput("p0w_hazard_clear", 32'(hazard), 32'd0);
    chk_a1 = 5'd0;

    // Both ports valid continuously: 4 grants to p0, then 1 to p1.
    applyStimulus(1'b1, 5'd1, 32'hA0A0A0A0, 1'b1, 5'd2, 32'hB1B1B1B1, 1'b0, 5'd0);
    for (int i = 0; i < 10; i++) begin
      checkOutput($sformatf("starve_p0_ready_%0d", i), 32'(p0_ready), ((i % 5) == 4) ? 32'd0 : 32'd1);
      checkOutput($sformatf("starve_p1_ready_%0d", i), 32'(p1_ready), ((i % 5) == 4) ? 32'd1 : 32'd0);
      tick();
      checkOutput($sformatf("starve_a3_%0d", i), 32'(a3), ((i % 5) == 4) ? 32'd2 : 32'd1);
      checkOutput($sformatf("starve_wd3_%0d", i), wd3, ((i % 5) == 4) ? 32'hB1B1B1B1 : 32'hA0A0A0A0);
    end
    idle();
    tick();

    // Issue to x7, then long-latency writeback of x7.
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
    tick();
    idle();
    chk_a1 = 5'd7;
    #1;
    checkOutput("x7_busy_hazard_a1", 32'(hazard), 32'(SB));
    chk_a1 = 5'd0;
    chk_a2 = 5'd7;
    #1;
    checkOutput("x7_busy_hazard_a2", 32'(hazard), 32'(SB));
    chk_a2 = 5'd0;
    chk_a1 = 5'd7;
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h00000077, 1'b0, 5'd0);
    checkOutput("x7_p1_ready", 32'(p1_ready), 32'd1);
    checkOutput("x7_hazard_before_edge", 32'(hazard), 32'(SB));
    tick();
    idle();
    checkOutput("x7_we3", 32'(we3), 32'd1);
    checkOutput("x7_hazard_inflight", 32'(hazard), 32'd1);
    tick();
    checkOutput("x7_hazard_clear", 32'(hazard), 32'd0);

    // Same-cycle issue and p1 clear of x9: set wins; p0 write does not clear.
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99999999, 1'b1, 5'd9);
    tick();
    idle();
    tick();
    chk_a1 = 5'd9;
    #1;
    checkOutput("x9_set_wins", 32'(hazard), 32'(SB));
    applyStimulus(1'b1, 5'd9, 32'h12345678, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    tick();
    idle();
    tick();
    checkOutput("x9_p0_no_clear", 32'(hazard), 32'(SB));
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99999999, 1'b0, 5'd0);
    tick();
    idle();
    tick();
    checkOutput("x9_p1_clear", 32'(hazard), 32'd0);

    // rd = 0 on either port and iss_rd = 0: handshake completes, no write.
    chk_a1 = 5'd0;
    applyStimulus(1'b1, 5'd0, 32'h00001234, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    checkOutput("x0_p0_ready", 32'(p0_ready), 32'd1);
    tick();
    checkOutput("x0_p0_we3", 32'(we3), 32'd0);
    checkOutput("x0_p0_a3", 32'(a3), 32'd0);
    checkOutput("x0_p0_wd3", wd3, 32'h00001234);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h00005678, 1'b1, 5'd0);
    checkOutput("x0_p1_ready", 32'(p1_ready), 32'd1);
    tick();
    idle();
    checkOutput("x0_p1_we3", 32'(we3), 32'd0);
    checkOutput("x0_p1_wd3", wd3, 32'h00005678);
    checkOutput("x0_hazard", 32'(hazard), 32'd0);

    // Reset mid-operation with busy[3], starve_cnt = 2 and a write in flight.
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3);
    tick();
    applyStimulus(1'b1, 5'd4, 32'h44444444, 1'b1, 5'd3, 32'h33333333, 1'b0, 5'd0);
    tick();
    tick();
    chk_a1 = 5'd3;
    #1;
    checkOutput("rst_pre_we3", 32'(we3), 32'd1);
    checkOutput("rst_pre_hazard", 32'(hazard), 32'(SB));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checkOutput("rst_we3", 32'(we3), 32'd0);
    checkOutput("rst_hazard", 32'(hazard), 32'd0);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("rst_cnt_p0_ready_%0d", i), 32'(p0_ready), (i == 4) ? 32'd0 : 32'd1);
      tick();
    end
    idle();
    tick();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
